// File: rtl/func_call_accum.sv
// Multi-channel call engine: result = arg + INC, summed into per-channel accumulators;
// non-void results are queued in an in-order response FIFO. Option: FUNC_CALL_ACCUM_SAT_EN.
module func_call_accum #(
   parameter int unsigned      WIDTH    = 32,
   parameter int unsigned      CHANNELS = 4,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [WIDTH-1:0] INC      = WIDTH'(1),
   parameter logic [WIDTH-1:0] ACC_INIT = WIDTH'(1),
   localparam int unsigned     CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [CW-1:0]       req_chan,
   input  logic [WIDTH-1:0]    req_arg,
   input  logic                req_void,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [CW-1:0]       rsp_chan,
   output logic [WIDTH-1:0]    rsp_data,
   input  logic [CHANNELS-1:0] acc_clr,
   input  logic [CW-1:0]       acc_sel,
   output logic [WIDTH-1:0]    acc_out,
`ifdef FUNC_CALL_ACCUM_SAT_EN
   output logic [CHANNELS-1:0] acc_sat,
`endif
   output logic [15:0]         call_cnt,
   output logic [15:0]         void_cnt
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] acc_q [CHANNELS];
   logic [WIDTH-1:0] acc_d [CHANNELS];
   logic [CW-1:0]    mem_chan_q [DEPTH];
   logic [WIDTH-1:0] mem_data_q [DEPTH];
   logic [PW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [15:0]      call_cnt_q, call_cnt_d, void_cnt_q, void_cnt_d;
   logic             fifo_full, fifo_empty, accept, chan_ok, push, pop;
   logic [WIDTH-1:0] v, base;
`ifdef FUNC_CALL_ACCUM_SAT_EN
   logic [CHANNELS-1:0] sat_q, sat_d;
   logic [WIDTH:0]      sum;
`endif

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   // A same-cycle pop deliberately does not relieve a full FIFO.
   assign req_ready  = !rst && (req_void || !fifo_full);
   assign accept     = req_valid && req_ready;
   assign chan_ok    = 32'(req_chan) < CHANNELS;
   assign push       = accept && chan_ok && !req_void;
   assign pop        = !fifo_empty && rsp_ready;
   assign v          = req_arg + INC;

   // Clear is applied first so a same-cycle call accumulates onto ACC_INIT.
   always_comb begin
      base = '0;
`ifdef FUNC_CALL_ACCUM_SAT_EN
      sum   = '0;
      sat_d = sat_q;
`endif
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         base     = acc_clr[c] ? ACC_INIT : acc_q[c];
         acc_d[c] = base;
`ifdef FUNC_CALL_ACCUM_SAT_EN
         if (acc_clr[c]) sat_d[c] = 1'b0;
         sum = {1'b0, base} + {1'b0, v};
         if (accept && chan_ok && (req_chan == CW'(c))) begin
            acc_d[c] = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
            if (sum[WIDTH]) sat_d[c] = 1'b1;
         end
`else
         if (accept && chan_ok && (req_chan == CW'(c))) acc_d[c] = base + v;
`endif
      end
   end

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      call_cnt_d = (accept && chan_ok) ? call_cnt_q + 16'd1 : call_cnt_q;
      void_cnt_d = (accept && chan_ok && req_void) ? void_cnt_q + 16'd1 : void_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned c = 0; c < CHANNELS; c++) acc_q[c] <= ACC_INIT;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         call_cnt_q <= '0;
         void_cnt_q <= '0;
`ifdef FUNC_CALL_ACCUM_SAT_EN
         sat_q      <= '0;
`endif
      end else begin
         for (int unsigned c = 0; c < CHANNELS; c++) acc_q[c] <= acc_d[c];
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         call_cnt_q <= call_cnt_d;
         void_cnt_q <= void_cnt_d;
`ifdef FUNC_CALL_ACCUM_SAT_EN
         sat_q      <= sat_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_chan_q[wr_ptr_q[PW-1:0]] <= req_chan;
         mem_data_q[wr_ptr_q[PW-1:0]] <= v;
      end
   end

   assign rsp_valid = !fifo_empty;
   assign rsp_chan  = mem_chan_q[rd_ptr_q[PW-1:0]];
   assign rsp_data  = mem_data_q[rd_ptr_q[PW-1:0]];
   assign acc_out   = (32'(acc_sel) < CHANNELS) ? acc_q[acc_sel] : '0;
   assign call_cnt  = call_cnt_q;
   assign void_cnt  = void_cnt_q;
`ifdef FUNC_CALL_ACCUM_SAT_EN
   assign acc_sat   = sat_q;
`endif

endmodule
